conv_layer_stream: RTL and testbench
====================================

Name: conv_layer_stream

Overview:
- Parametrised streaming KxK convolution layer for the DNN pipeline. Generalises the fixed 3x3 CONV_1/CONV_2 stages to any kernel size, with runtime-loadable weights, a bias, a requantising shift, optional ReLU and output backpressure.
- Consumes the input grid one row per beat and keeps the previous K-1 rows in a line buffer.
- Emits one valid-padding output row per accepted input row once the window is full.
- Sits between the input-grid stage and the classifier stages.

Parameters:
- DATA_WIDTH, 8: signed width of activations, weights and bias.
- ROW_NUM, 8: rows per frame. Must be >= K.
- COL_NUM, 8: elements per input row. Must be >= K.
- K, 3: kernel height and width.
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- en  in  1  global enable. When low, all state and outputs hold, and input_ready and w_ready read 0.
- w_iv  in  1  weight word valid.
- w_id  in  DATA_WIDTH  weight word. Order: K*K weights row-major, then bias.
- w_ready  out  1  weight port can accept.
- relu_en  in  1  ReLU mode. Sampled on the same edge as each input row.
- input_grid_iv  in  1  input row valid.
- row_input_id  in  COL_NUM x DATA_WIDTH  unpacked array of signed input row elements.
- input_ready  out  1  input row accepted when iv && ready.
- output_ov  out  1  output row valid.
- output_od  out  (COL_NUM-K+1) x DATA_WIDTH  unpacked array of signed output row elements.
- output_last  out  1  marks the final output row of a frame.
- output_ready  in  1  downstream accepts the output row.

Behaviour:
- Reset values: output_ov=0, output_last=0, output_od all 0, w_ready=1, input_ready=0. Weights, bias, line buffer, row counter and weight counter cleared; weights_valid=0.
- Reset mid-frame discards the partial frame and the loaded weights; a full weight load is required again.
- FSM states:
  - W_LOAD: weights incomplete.
  - FRAME_IDLE: weights valid, row_cnt=0, no pending output.
  - FRAME_RUN: 0<row_cnt or output pending.
- Weight load:
  - w_ready = en && state!=FRAME_RUN.
  - Each w_iv&&w_ready writes word w_idx. w_idx increments and wraps after K*K+1 words.
  - On the wrap, weights_valid=1 and state goes to FRAME_IDLE.
  - A new load starting from FRAME_IDLE clears weights_valid on its first word and re-enters W_LOAD.
  - w_iv while w_ready=0 is ignored; the word is lost and the bench must not drive it.
- Input handshake: input_ready = en && weights_valid && (!output_ov || output_ready).
- On row acceptance:
  - The row shifts into the K-1 deep line buffer.
  - row_cnt increments and wraps to 0 after ROW_NUM-1.
- Output timing:
  - If the accepted row index r >= K-1, output_ov=1 on the next edge with output row r-K+1.
  - Latency is 1 cycle from acceptance to output_ov.
  - output_last=1 when r==ROW_NUM-1.
  - Rows with r<K-1 produce no output.
- Output hold: output_ov && !output_ready holds output_od/output_last stable and forces input_ready=0.
- Output clear: output_ov clears after output_ready unless a new row is accepted on the same edge. That simultaneous case is a back-to-back stream.
- Frames may be back-to-back: row 0 of the next frame is accepted on the cycle after the last row of the previous frame.
- Arithmetic for each output column i:
  - acc = sum over (a,b) of w[a][b]*x[row r-K+1+a][col i+b] + sign-extended bias.
  - ACC_WIDTH = 2*DATA_WIDTH + clog2(K*K) + 1, so the sum never overflows.
  - res = acc >>> SHIFT.
  - If relu_en and res<0, res=0.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].

Decomposition:
- Shared package dnn_pkg contains:
  - the conv state enum (W_LOAD, FRAME_IDLE, FRAME_RUN);
  - the acc_width(DATA_WIDTH,K) function;
  - the sat_signed() function.
- Sub-module conv_window_mac: combinational KxK signed dot product, bias add, shift, ReLU and saturate for one output element. It is instantiated COL_NUM-K+1 times in a generate loop.
- The top level holds the FSM, counters, line buffer and output register.

Test Plan:
- Identity kernel (centre=1, others 0, bias 0, SHIFT 0) + 8x8 frame with x[r][c]=8r+c:
  - 6 output rows, output_od[j][i]=8(j+1)+(i+1);
  - output_last only on row 5;
  - each output_ov 1 cycle after input rows 2..7.
- Saturation: all weights 127, all inputs 127 -> every output 127. Weights -127 -> -128. Weights -127 with relu_en=1 -> 0.
- Backpressure: output_ready=0 for 3 cycles while output_ov -> output_od stable, input_ready=0; rows resume on release with no loss or duplication.
- Weight guard: w_iv driven mid-frame -> w_ready=0, weights unchanged, frame outputs match identity results. Reload between frames with bias=5 -> next frame outputs +5.
- Reset mid-frame: assert nrst=0 after row 4 -> all outputs 0 at once, input_ready=0 until a full K*K+1 weight load completes.
- en=0 for 2 cycles mid-frame -> no handshakes, state held, final outputs identical to the uninterrupted run.

Source files
------------

// File: rtl/dnn_pkg.sv
// Shared types and helpers for the DNN streaming pipeline.
// Holds the conv FSM state type and the arithmetic sizing helpers.
package dnn_pkg;

  typedef enum logic [1:0] {
    W_LOAD,
    FRAME_IDLE,
    FRAME_RUN
  } conv_state_e;

  function automatic int acc_width(input int dw, input int k);
    return 2 * dw + $clog2(k * k) + 1;
  endfunction

  function automatic logic signed [63:0] sat_signed(
    input logic signed [63:0] v,
    input int                 dw
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/conv_window_mac.sv
// One output element of the KxK conv: dot product, bias,
// requantising shift, optional ReLU and saturation.
module conv_window_mac
  import dnn_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int K          = 3,
  parameter int SHIFT      = 0
) (
  input  logic signed [DATA_WIDTH-1:0] win [K*K],
  input  logic signed [DATA_WIDTH-1:0] wts [K*K],
  input  logic signed [DATA_WIDTH-1:0] bias,
  input  logic                         relu_en,
  output logic signed [DATA_WIDTH-1:0] res
);

  localparam int ACC_W = acc_width(DATA_WIDTH, K);

  logic signed [ACC_W-1:0]        acc;
  logic signed [ACC_W-1:0]        shd;
  logic signed [2*DATA_WIDTH-1:0] prod;

  // Accumulate, shift, rectify and clamp to the activation range.
  always_comb begin
    acc  = ACC_W'(bias);
    prod = '0;
    for (int i = 0; i < K * K; i++) begin
      prod = wts[i] * win[i];
      acc  = acc + ACC_W'(prod);
    end
    shd = acc >>> SHIFT;
    if (relu_en && shd < 0) shd = '0;
    res = DATA_WIDTH'(sat_signed(64'(shd), DATA_WIDTH));
  end

endmodule

// File: rtl/conv_layer_stream.sv
// Streaming KxK valid-padding conv layer, one row per beat,
// with loadable weights/bias and registered, backpressured output.
module conv_layer_stream
  import dnn_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_NUM    = 8,
  parameter int COL_NUM    = 8,
  parameter int K          = 3,
  parameter int SHIFT      = 0
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         en,
  input  logic                         w_iv,
  input  logic signed [DATA_WIDTH-1:0] w_id,
  output logic                         w_ready,
  input  logic                         relu_en,
  input  logic                         input_grid_iv,
  input  logic signed [DATA_WIDTH-1:0] row_input_id [COL_NUM],
  output logic                         input_ready,
  output logic                         output_ov,
  output logic signed [DATA_WIDTH-1:0] output_od [COL_NUM-K+1],
  output logic                         output_last,
  input  logic                         output_ready
);

  localparam int OC = COL_NUM - K + 1;
  localparam int NW = K * K;
  localparam int LB = K - 1;
  localparam int WW = $clog2(NW + 1);
  localparam int RW = $clog2(ROW_NUM);

  localparam logic [WW-1:0] W_LAST = WW'(NW);
  localparam logic [RW-1:0] R_LAST = RW'(ROW_NUM - 1);
  localparam logic [RW-1:0] R_OUT0 = RW'(K - 1);

  conv_state_e state;
  conv_state_e state_nx;

  logic [WW-1:0] w_idx;
  logic [RW-1:0] row_cnt;
  logic [RW-1:0] rc_nx;
  logic          weights_valid;
  logic          wv_nx;
  logic          ov_nx;
  logic          w_fire;
  logic          in_fire;
  logic          emit;

  logic signed [DATA_WIDTH-1:0] weights [NW];
  logic signed [DATA_WIDTH-1:0] bias;
  logic signed [DATA_WIDTH-1:0] lb [LB][COL_NUM];
  logic signed [DATA_WIDTH-1:0] mac_res [OC];

  assign w_ready     = en && (state != FRAME_RUN);
  assign input_ready = en && weights_valid &&
                       (!output_ov || output_ready);
  assign w_fire      = w_iv && w_ready;
  assign in_fire     = input_grid_iv && input_ready;
  assign emit        = in_fire && (row_cnt >= R_OUT0);

  // Next-state for weight validity, row counter, output valid and FSM.
  always_comb begin
    wv_nx    = weights_valid;
    rc_nx    = row_cnt;
    ov_nx    = output_ov;
    state_nx = state;
    if (w_fire) begin
      if (w_idx == W_LAST) wv_nx = 1'b1;
      else if (w_idx == '0) wv_nx = 1'b0;
    end
    if (in_fire) begin
      rc_nx = (row_cnt == R_LAST) ? '0 : row_cnt + 1'b1;
    end
    if (en) begin
      if (output_ov && output_ready) ov_nx = 1'b0;
      if (emit) ov_nx = 1'b1;
    end
    case (state)
      W_LOAD: begin
        if (wv_nx) state_nx = FRAME_IDLE;
      end
      default: begin
        if (!wv_nx) state_nx = W_LOAD;
        else if (rc_nx != '0 || ov_nx) state_nx = FRAME_RUN;
        else state_nx = FRAME_IDLE;
      end
    endcase
  end

  // Control registers: FSM, counters, weight validity.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state         <= W_LOAD;
      w_idx         <= '0;
      row_cnt       <= '0;
      weights_valid <= 1'b0;
    end else begin
      state         <= state_nx;
      row_cnt       <= rc_nx;
      weights_valid <= wv_nx;
      if (w_fire) w_idx <= (w_idx == W_LAST) ? '0 : w_idx + 1'b1;
    end
  end

  // Weight and bias storage, written word by word in load order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NW; i++) weights[i] <= '0;
      bias <= '0;
    end else if (w_fire) begin
      if (w_idx == W_LAST) bias <= w_id;
      else weights[w_idx] <= w_id;
    end
  end

  // Line buffer: lb[0] is the newest row, lb[LB-1] the oldest.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int j = 0; j < LB; j++)
        for (int c = 0; c < COL_NUM; c++) lb[j][c] <= '0;
    end else if (in_fire) begin
      lb[0] <= row_input_id;
      for (int j = 1; j < LB; j++) lb[j] <= lb[j-1];
    end
  end

  // Output register: load on emitting rows, hold under backpressure.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      output_ov   <= 1'b0;
      output_last <= 1'b0;
      for (int i = 0; i < OC; i++) output_od[i] <= '0;
    end else begin
      output_ov <= ov_nx;
      if (emit) begin
        output_od   <= mac_res;
        output_last <= (row_cnt == R_LAST);
      end
    end
  end

  for (genvar i = 0; i < OC; i++) begin : g_col
    logic signed [DATA_WIDTH-1:0] win [NW];
    for (genvar a = 0; a < K; a++) begin : g_row
      for (genvar b = 0; b < K; b++) begin : g_tap
        if (a == K - 1) begin : g_new
          assign win[a*K+b] = row_input_id[i+b];
        end else begin : g_old
          assign win[a*K+b] = lb[K-2-a][i+b];
        end
      end
    end
    conv_window_mac #(
      .DATA_WIDTH(DATA_WIDTH),
      .K         (K),
      .SHIFT     (SHIFT)
    ) u_mac (
      .win    (win),
      .wts    (weights),
      .bias   (bias),
      .relu_en(relu_en),
      .res    (mac_res[i])
    );
  end

endmodule

// File: tb/tb_conv_layer_stream.sv
// Directed bench for conv_layer_stream with default 8x8, K=3.
// Each scenario task drives rows and checks outputs inline.
module tb_conv_layer_stream;

  localparam int DW = 8;
  localparam int RN = 8;
  localparam int CN = 8;
  localparam int KK = 3;
  localparam int OC = CN - KK + 1;

  logic                 clk;
  logic                 nrst;
  logic                 en;
  logic                 w_iv;
  logic signed [DW-1:0] w_id;
  logic                 w_ready;
  logic                 relu_en;
  logic                 input_grid_iv;
  logic signed [DW-1:0] row_input_id [CN];
  logic                 input_ready;
  logic                 output_ov;
  logic signed [DW-1:0] output_od [OC];
  logic                 output_last;
  logic                 output_ready;

  int checks;
  int failures;
  int cyc;

  logic [OC*DW-1:0] got_q [$];
  bit               last_q [$];
  int               acc_q [$];

  conv_layer_stream #(
    .DATA_WIDTH(DW), .ROW_NUM(RN), .COL_NUM(CN), .K(KK), .SHIFT(0)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .en           (en),
    .w_iv         (w_iv),
    .w_id         (w_id),
    .w_ready      (w_ready),
    .relu_en      (relu_en),
    .input_grid_iv(input_grid_iv),
    .row_input_id (row_input_id),
    .input_ready  (input_ready),
    .output_ov    (output_ov),
    .output_od    (output_od),
    .output_last  (output_last),
    .output_ready (output_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [OC*DW-1:0] pack_od();
    logic [OC*DW-1:0] v;
    for (int i = 0; i < OC; i++) v[i*DW +: DW] = output_od[i];
    return v;
  endfunction

  function automatic logic [OC*DW-1:0] exp_ident(int j, int b);
    logic [OC*DW-1:0] v;
    for (int i = 0; i < OC; i++)
      v[i*DW +: DW] = DW'(8 * (j + 1) + (i + 1) + b);
    return v;
  endfunction

  function automatic logic [OC*DW-1:0] exp_const(int c);
    logic [OC*DW-1:0] v;
    for (int i = 0; i < OC; i++) v[i*DW +: DW] = DW'(c);
    return v;
  endfunction

  // Record transfers at the negedge preceding the capturing posedge.
  always @(negedge clk) begin
    if (nrst && en && output_ov && output_ready) begin
      got_q.push_back(pack_od());
      last_q.push_back(output_last);
    end
    if (nrst && input_grid_iv && input_ready) acc_q.push_back(cyc);
  end

  task automatic load_weights(input bit ident, input int wv,
                              input int b);
    bit ok;
    int n;
    for (int k = 0; k <= KK * KK; k++) begin
      w_iv = 1'b1;
      if (k == KK * KK) w_id = DW'(b);
      else if (ident) w_id = (k == 4) ? 8'sd1 : 8'sd0;
      else w_id = DW'(wv);
      n = 0;
      do begin
        @(negedge clk);
        ok = w_ready;
        @(posedge clk);
        #1;
        n++;
      end while (!ok && n < 50);
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL w_load_timeout word=%0d got=0 need=1", k);
      end
    end
    w_iv = 1'b0;
  endtask

  task automatic send_row(input int r, input int mode, input bit relu);
    bit ok;
    int n;
    input_grid_iv = 1'b1;
    relu_en       = relu;
    for (int c = 0; c < CN; c++)
      row_input_id[c] = (mode == 0) ? DW'(8 * r + c) : 8'sd127;
    n = 0;
    do begin
      @(negedge clk);
      ok = input_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL row_timeout row=%0d got=0 need=1", r);
    end
    input_grid_iv = 1'b0;
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bit zero;
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    zero = 1'b1;
    for (int i = 0; i < OC; i++) if (output_od[i] !== '0) zero = 1'b0;
    checks++;
    if (output_ov !== 1'b0) begin
      failures++;
      $display("FAIL rst_ov got=%0b need=0", output_ov);
    end
    checks++;
    if (output_last !== 1'b0) begin
      failures++;
      $display("FAIL rst_last got=%0b need=0", output_last);
    end
    checks++;
    if (zero !== 1'b1) begin
      failures++;
      $display("FAIL rst_od got=%h need=0", pack_od());
    end
    checks++;
    if (w_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_w_ready got=%0b need=1", w_ready);
    end
    checks++;
    if (input_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_in_ready got=%0b need=0", input_ready);
    end
    nrst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (input_ready !== 1'b0) begin
      failures++;
      $display("FAIL nowts_in_ready got=%0b need=0", input_ready);
    end
  endtask

  task automatic test_identity();
    load_weights(1'b1, 0, 0);
    got_q.delete();
    last_q.delete();
    for (int r = 0; r < RN; r++) begin
      send_row(r, 0, 1'b0);
      checks++;
      if (output_ov !== (r >= KK - 1)) begin
        failures++;
        $display("FAIL id_latency row=%0d got=%0b need=%0b",
                 r, output_ov, (r >= KK - 1));
      end
    end
    drain();
    checks++;
    if (got_q.size() != 6) begin
      failures++;
      $display("FAIL id_count got=%0d need=6", got_q.size());
    end
    for (int j = 0; j < 6 && j < got_q.size(); j++) begin
      checks++;
      if (got_q[j] !== exp_ident(j, 0)) begin
        failures++;
        $display("FAIL id_row%0d got=%h need=%h",
                 j, got_q[j], exp_ident(j, 0));
      end
      checks++;
      if (last_q[j] !== (j == 5)) begin
        failures++;
        $display("FAIL id_last%0d got=%0b need=%0b",
                 j, last_q[j], (j == 5));
      end
    end
  endtask

  task automatic test_back_to_back();
    got_q.delete();
    last_q.delete();
    acc_q.delete();
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < RN; r++) send_row(r, 0, 1'b0);
    drain();
    checks++;
    if (got_q.size() != 12) begin
      failures++;
      $display("FAIL b2b_count got=%0d need=12", got_q.size());
    end
    for (int j = 0; j < 12 && j < got_q.size(); j++) begin
      checks++;
      if (got_q[j] !== exp_ident(j % 6, 0) ||
          last_q[j] !== (j % 6 == 5)) begin
        failures++;
        $display("FAIL b2b_row%0d got=%h/%0b need=%h/%0b", j,
                 got_q[j], last_q[j], exp_ident(j % 6, 0),
                 (j % 6 == 5));
      end
    end
    checks++;
    if (acc_q.size() != 16 || acc_q[8] != acc_q[7] + 1) begin
      failures++;
      $display("FAIL b2b_gap got=%0d need=1",
               (acc_q.size() == 16) ? acc_q[8] - acc_q[7] : -1);
    end
  endtask

  task automatic test_saturation();
    int wv [3];
    bit rl [3];
    int ex [3];
    wv = '{127, -127, -127};
    rl = '{1'b0, 1'b0, 1'b1};
    ex = '{127, -128, 0};
    for (int t = 0; t < 3; t++) begin
      load_weights(1'b0, wv[t], 0);
      got_q.delete();
      last_q.delete();
      for (int r = 0; r < RN; r++) send_row(r, 1, rl[t]);
      drain();
      checks++;
      if (got_q.size() != 6) begin
        failures++;
        $display("FAIL sat%0d_count got=%0d need=6", t, got_q.size());
      end
      for (int j = 0; j < got_q.size(); j++) begin
        checks++;
        if (got_q[j] !== exp_const(ex[t])) begin
          failures++;
          $display("FAIL sat%0d_row%0d got=%h need=%h",
                   t, j, got_q[j], exp_const(ex[t]));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    load_weights(1'b1, 0, 0);
    got_q.delete();
    last_q.delete();
    acc_q.delete();
    for (int r = 0; r < 4; r++) send_row(r, 0, 1'b0);
    output_ready  = 1'b0;
    input_grid_iv = 1'b1;
    for (int c = 0; c < CN; c++) row_input_id[c] = DW'(32 + c);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (pack_od() !== exp_ident(1, 0) || output_ov !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold got=%h/%0b need=%h/1",
                 pack_od(), output_ov, exp_ident(1, 0));
      end
      checks++;
      if (input_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_in_ready got=%0b need=0", input_ready);
      end
    end
    @(posedge clk);
    #1;
    output_ready = 1'b1;
    for (int r = 4; r < RN; r++) send_row(r, 0, 1'b0);
    drain();
    checks++;
    if (got_q.size() != 6 || acc_q.size() != 8) begin
      failures++;
      $display("FAIL bp_count got=%0d/%0d need=6/8",
               got_q.size(), acc_q.size());
    end
    for (int j = 0; j < 6 && j < got_q.size(); j++) begin
      checks++;
      if (got_q[j] !== exp_ident(j, 0)) begin
        failures++;
        $display("FAIL bp_row%0d got=%h need=%h",
                 j, got_q[j], exp_ident(j, 0));
      end
    end
  endtask

  task automatic test_en_pause();
    got_q.delete();
    acc_q.delete();
    for (int r = 0; r < 4; r++) send_row(r, 0, 1'b0);
    en            = 1'b0;
    input_grid_iv = 1'b1;
    for (int c = 0; c < CN; c++) row_input_id[c] = DW'(32 + c);
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (input_ready !== 1'b0 || w_ready !== 1'b0) begin
        failures++;
        $display("FAIL en_ready got=%0b/%0b need=0/0",
                 input_ready, w_ready);
      end
      checks++;
      if (output_ov !== 1'b1 || pack_od() !== exp_ident(1, 0)) begin
        failures++;
        $display("FAIL en_hold got=%h/%0b need=%h/1",
                 pack_od(), output_ov, exp_ident(1, 0));
      end
    end
    @(posedge clk);
    #1;
    en = 1'b1;
    for (int r = 4; r < RN; r++) send_row(r, 0, 1'b0);
    drain();
    checks++;
    if (got_q.size() != 6 || acc_q.size() != 8) begin
      failures++;
      $display("FAIL en_count got=%0d/%0d need=6/8",
               got_q.size(), acc_q.size());
    end
    for (int j = 0; j < 6 && j < got_q.size(); j++) begin
      checks++;
      if (got_q[j] !== exp_ident(j, 0)) begin
        failures++;
        $display("FAIL en_row%0d got=%h need=%h",
                 j, got_q[j], exp_ident(j, 0));
      end
    end
  endtask

  task automatic test_weight_guard();
    got_q.delete();
    for (int r = 0; r < 4; r++) send_row(r, 0, 1'b0);
    w_iv = 1'b1;
    w_id = 8'sd99;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (w_ready !== 1'b0) begin
        failures++;
        $display("FAIL wg_w_ready got=%0b need=0", w_ready);
      end
      @(posedge clk);
      #1;
    end
    w_iv = 1'b0;
    for (int r = 4; r < RN; r++) send_row(r, 0, 1'b0);
    drain();
    for (int j = 0; j < 6 && j < got_q.size(); j++) begin
      checks++;
      if (got_q[j] !== exp_ident(j, 0)) begin
        failures++;
        $display("FAIL wg_row%0d got=%h need=%h",
                 j, got_q[j], exp_ident(j, 0));
      end
    end
    load_weights(1'b1, 0, 5);
    got_q.delete();
    for (int r = 0; r < RN; r++) send_row(r, 0, 1'b0);
    drain();
    checks++;
    if (got_q.size() != 6) begin
      failures++;
      $display("FAIL wg_bias_count got=%0d need=6", got_q.size());
    end
    for (int j = 0; j < 6 && j < got_q.size(); j++) begin
      checks++;
      if (got_q[j] !== exp_ident(j, 5)) begin
        failures++;
        $display("FAIL wg_bias_row%0d got=%h need=%h",
                 j, got_q[j], exp_ident(j, 5));
      end
    end
  endtask

  task automatic test_reset_midframe();
    bit zero;
    for (int r = 0; r < 5; r++) send_row(r, 0, 1'b0);
    nrst = 1'b0;
    #1;
    zero = 1'b1;
    for (int i = 0; i < OC; i++) if (output_od[i] !== '0) zero = 1'b0;
    checks++;
    if (output_ov !== 1'b0 || output_last !== 1'b0 || !zero) begin
      failures++;
      $display("FAIL rm_outs got=%h/%0b/%0b need=0/0/0",
               pack_od(), output_ov, output_last);
    end
    checks++;
    if (input_ready !== 1'b0) begin
      failures++;
      $display("FAIL rm_in_ready got=%0b need=0", input_ready);
    end
    @(posedge clk);
    #1;
    nrst = 1'b1;
    for (int k = 0; k < KK * KK; k++) begin
      w_iv = 1'b1;
      w_id = (k == 4) ? 8'sd1 : 8'sd0;
      @(negedge clk);
      checks++;
      if (input_ready !== 1'b0) begin
        failures++;
        $display("FAIL rm_partial k=%0d got=%0b need=0", k, input_ready);
      end
      @(posedge clk);
      #1;
    end
    w_id = 8'sd0;
    @(negedge clk);
    checks++;
    if (input_ready !== 1'b0) begin
      failures++;
      $display("FAIL rm_before_bias got=%0b need=0", input_ready);
    end
    @(posedge clk);
    #1;
    w_iv = 1'b0;
    @(negedge clk);
    checks++;
    if (input_ready !== 1'b1) begin
      failures++;
      $display("FAIL rm_loaded got=%0b need=1", input_ready);
    end
    @(posedge clk);
    #1;
    got_q.delete();
    last_q.delete();
    for (int r = 0; r < RN; r++) send_row(r, 0, 1'b0);
    drain();
    checks++;
    if (got_q.size() != 6) begin
      failures++;
      $display("FAIL rm_count got=%0d need=6", got_q.size());
    end
    for (int j = 0; j < 6 && j < got_q.size(); j++) begin
      checks++;
      if (got_q[j] !== exp_ident(j, 0) || last_q[j] !== (j == 5)) begin
        failures++;
        $display("FAIL rm_row%0d got=%h need=%h",
                 j, got_q[j], exp_ident(j, 0));
      end
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    cyc           = 0;
    nrst          = 1'b0;
    en            = 1'b1;
    w_iv          = 1'b0;
    w_id          = '0;
    relu_en       = 1'b0;
    input_grid_iv = 1'b0;
    output_ready  = 1'b1;
    for (int c = 0; c < CN; c++) row_input_id[c] = '0;
    test_reset();
    test_identity();
    test_back_to_back();
    test_saturation();
    test_backpressure();
    test_en_pause();
    test_weight_guard();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
